// File: rtl/nn_pkg.sv
// Shared definitions for the CPU_NN datapath: ALU opcodes, the neuron
// sequencer state encoding and the maximum fan-in per neuron.
package nn_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_MUL  = 3'b001;
    localparam logic [2:0] ALU_SNN  = 3'b010;
    localparam logic [2:0] ALU_PASS = 3'b111;

    localparam int MAX_N = 16;

    typedef enum logic [2:0] {
        SEQ_IDLE = 3'd0,
        SEQ_MUL  = 3'd1,
        SEQ_ADD  = 3'd2,
        SEQ_ACT  = 3'd3,
        SEQ_DONE = 3'd4
    } seq_state_e;

endpackage

// File: rtl/neuron_op_sequencer.sv
// Drives the execution-unit ALU through MUL/ADD pairs and one activation op to
// evaluate y = act(bias + sum x[i]*w[i]). Define NEURON_SEQ_RELU_EN for ReLU, else 0/1 step.
module neuron_op_sequencer
    import nn_pkg::*;
#(
    parameter int nBits = 32,
    parameter int MAX_N = nn_pkg::MAX_N,
    parameter int IDX_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [IDX_W:0]    num_inputs,
    input  logic [nBits-1:0]  bias,
    output logic [IDX_W-1:0]  rd_addr,
    input  logic [nBits-1:0]  rd_x,
    input  logic [nBits-1:0]  rd_w,
    output logic [2:0]        ALU1Control,
    output logic [nBits-1:0]  SrcA,
    output logic [nBits-1:0]  SrcB,
    input  logic [nBits-1:0]  ALUResult,
    output logic              busy,
    output logic              done,
    output logic [nBits-1:0]  acc,
    output logic [nBits-1:0]  y,
    output seq_state_e        state_dbg
);

    // Handshake: start is sampled only while busy is low; a start seen while
    // busy is dropped, never queued. done pulses for exactly one cycle once acc
    // and y are final, and busy falls on the following edge.

    localparam logic [IDX_W:0] MAX_N_W = (IDX_W+1)'(MAX_N);

    seq_state_e        state;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W:0]    n_reg;
    logic [nBits-1:0]  prod;
    logic [IDX_W:0]    n_clamped;
    logic              last_pair;

    assign n_clamped = (num_inputs > MAX_N_W) ? MAX_N_W : num_inputs;
    assign last_pair = ({1'b0, idx} == (n_reg - (IDX_W+1)'(1)));
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= SEQ_IDLE;
            idx         <= '0;
            n_reg       <= '0;
            prod        <= '0;
            acc         <= '0;
            y           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_addr     <= '0;
            ALU1Control <= ALU_PASS;
        end else begin
            done <= 1'b0;
            case (state)
                SEQ_IDLE: begin
                    if (start) begin
                        acc   <= bias;
                        n_reg <= n_clamped;
                        idx   <= '0;
                        busy  <= 1'b1;
                        if (n_clamped != '0) begin
                            state       <= SEQ_MUL;
                            ALU1Control <= ALU_MUL;
                            rd_addr     <= '0;
                        end else begin
                            state       <= SEQ_ACT;
                            ALU1Control <= ALU_SNN;
                        end
                    end
                end
                SEQ_MUL: begin
                    prod        <= ALUResult;
                    state       <= SEQ_ADD;
                    ALU1Control <= ALU_ADD;
                    rd_addr     <= '0;
                end
                SEQ_ADD: begin
                    acc <= ALUResult;
                    if (last_pair) begin
                        state       <= SEQ_ACT;
                        ALU1Control <= ALU_SNN;
                    end else begin
                        // rd_addr is loaded with the next index so it is valid
                        // on the first cycle of the following MUL.
                        idx         <= idx + 1'b1;
                        rd_addr     <= idx + 1'b1;
                        state       <= SEQ_MUL;
                        ALU1Control <= ALU_MUL;
                    end
                end
                SEQ_ACT: begin
`ifdef NEURON_SEQ_RELU_EN
                    y <= ALUResult[0] ? acc : '0;
`else
                    y <= ALUResult;
`endif
                    state       <= SEQ_DONE;
                    ALU1Control <= ALU_PASS;
                    done        <= 1'b1;
                end
                SEQ_DONE: begin
                    state <= SEQ_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state       <= SEQ_IDLE;
                    busy        <= 1'b0;
                    ALU1Control <= ALU_PASS;
                    rd_addr     <= '0;
                end
            endcase
        end
    end

    // Operands follow the registered state; MUL operands come straight from the
    // register files, which answer combinationally to rd_addr.
    always_comb begin
        SrcA = acc;
        SrcB = '0;
        case (state)
            SEQ_MUL: begin
                SrcA = rd_x;
                SrcB = rd_w;
            end
            SEQ_ADD: SrcB = prod;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_neuron_op_sequencer.sv
// Randomized and directed bench for neuron_op_sequencer with a behavioural ALU
// and register files; results are checked against a sum-of-products model.
module tb_neuron_op_sequencer;
    import nn_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [4:0]  num_inputs;
    logic [31:0] bias;
    logic [3:0]  rd_addr;
    logic [31:0] rd_x, rd_w;
    logic [2:0]  ALU1Control;
    logic [31:0] SrcA, SrcB, ALUResult;
    logic        busy, done;
    logic [31:0] acc, y;
    seq_state_e  state_dbg;

    logic [31:0] x_mem [16];
    logic [31:0] w_mem [16];
    logic [31:0] exp_q [$];
    logic [31:0] addr_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    neuron_op_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_inputs(num_inputs),
        .bias(bias), .rd_addr(rd_addr), .rd_x(rd_x), .rd_w(rd_w),
        .ALU1Control(ALU1Control), .SrcA(SrcA), .SrcB(SrcB), .ALUResult(ALUResult),
        .busy(busy), .done(done), .acc(acc), .y(y), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    // behavioural ALU and register files
    assign rd_x = x_mem[rd_addr];
    assign rd_w = w_mem[rd_addr];
    always_comb begin
        case (ALU1Control)
            3'b000:  ALUResult = SrcA + SrcB;
            3'b001:  ALUResult = SrcA * SrcB;
            3'b010:  ALUResult = ($signed(SrcA) >= $signed(SrcB)) ? 32'd1 : 32'd0;
            3'b111:  ALUResult = SrcA;
            default: ALUResult = 32'd0;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, expv);
        end
    endtask

    function automatic logic [31:0] model_y(input logic [31:0] a);
`ifdef NEURON_SEQ_RELU_EN
        return a[31] ? 32'd0 : a;
`else
        return a[31] ? 32'd0 : 32'd1;
`endif
    endfunction

    // Called at a negedge with the DUT idle; drives start in this cycle (cycle 0).
    task automatic run_case(input string tag, input int n_raw, input logic [31:0] b,
                            input int poke_cycle);
        int n;
        int limit;
        bit seen;
        logic [31:0] exp_acc;
        n = (n_raw > 16) ? 16 : n_raw;
        exp_acc = b;
        for (int i = 0; i < n; i++) exp_acc = exp_acc + x_mem[i] * w_mem[i];
        exp_q.delete();
        addr_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(32'(ALU_MUL));  addr_q.push_back(32'(i));
            exp_q.push_back(32'(ALU_ADD));  addr_q.push_back(32'd0);
        end
        exp_q.push_back(32'(ALU_SNN));  addr_q.push_back(32'd0);
        exp_q.push_back(32'(ALU_PASS)); addr_q.push_back(32'd0);

        start      = 1'b1;
        num_inputs = 5'(n_raw);
        bias       = b;
        check_eq({tag, ".idle_op"}, 32'(ALU1Control), 32'(ALU_PASS));
        @(negedge clk);
        // operands change after the start edge and must not disturb the run
        num_inputs = 5'($urandom_range(0, 31));
        bias       = $urandom;
        seen  = 1'b0;
        limit = 2 * n + 6;
        for (int cyc = 1; cyc <= limit && !seen; cyc++) begin
            start = (cyc == poke_cycle);
            if (exp_q.size() > 0) begin
                check_eq({tag, ".op"}, 32'(ALU1Control), exp_q.pop_front());
                check_eq({tag, ".addr"}, 32'(rd_addr), addr_q.pop_front());
            end
            check_eq({tag, ".busy"}, 32'(busy), 32'd1);
            if (done) begin
                seen = 1'b1;
                check_eq({tag, ".done_cycle"}, 32'(cyc), 32'(2 * n + 2));
                check_eq({tag, ".acc"}, acc, exp_acc);
                check_eq({tag, ".y"}, y, model_y(exp_acc));
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!seen) check_eq({tag, ".done_timeout"}, 32'd0, 32'd1);
        check_eq({tag, ".done_pulse"}, 32'(done), 32'd0);
        check_eq({tag, ".busy_after"}, 32'(busy), 32'd0);
        check_eq({tag, ".acc_hold"}, acc, exp_acc);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, ".busy"}, 32'(busy), 32'd0);
        check_eq({tag, ".done"}, 32'(done), 32'd0);
        check_eq({tag, ".acc"}, acc, 32'd0);
        check_eq({tag, ".y"}, y, 32'd0);
        check_eq({tag, ".rd_addr"}, 32'(rd_addr), 32'd0);
        check_eq({tag, ".srca"}, SrcA, 32'd0);
        check_eq({tag, ".srcb"}, SrcB, 32'd0);
        check_eq({tag, ".op"}, 32'(ALU1Control), 32'(ALU_PASS));
        check_eq({tag, ".state"}, 32'(state_dbg), 32'(SEQ_IDLE));
    endtask

    task automatic load_mem(input logic [31:0] xv, input logic [31:0] wv);
        for (int i = 0; i < 16; i++) begin
            x_mem[i] = xv;
            w_mem[i] = wv;
        end
    endtask

    initial begin
        int done_count;
        int n_rand;
        reset_n    = 1'b0;
        start      = 1'b0;
        num_inputs = '0;
        bias       = '0;
        load_mem(32'd0, 32'd0);
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset_n = 1'b1;

        // basic dot product
        x_mem[0] = 1; x_mem[1] = 2; x_mem[2] = 3;
        w_mem[0] = 4; w_mem[1] = 5; w_mem[2] = 6;
        run_case("dot3", 3, 32'd0, -1);
        run_case("dot3_neg", 3, 32'hFFFF_FFD8, -1);
        run_case("n0", 0, 32'd5, -1);

        // clamp plus ignored start mid-run
        load_mem(32'd1, 32'd1);
        run_case("clamp", 20, 32'd0, 10);

        // reset during an ADD cycle
        x_mem[0] = 1; x_mem[1] = 2; x_mem[2] = 3;
        w_mem[0] = 4; w_mem[1] = 5; w_mem[2] = 6;
        start = 1'b1; num_inputs = 5'd3; bias = 32'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_eq("mid.add_op", 32'(ALU1Control), 32'(ALU_ADD));
        reset_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        @(negedge clk);
        reset_n = 1'b1;
        done_count = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) done_count++;
            @(negedge clk);
        end
        check_eq("mid.no_done", 32'(done_count), 32'd0);
        x_mem[0] = 2; x_mem[1] = 3;
        w_mem[0] = 2; w_mem[1] = 3;
        run_case("after_reset", 2, 32'd0, -1);

        // product wraps past the sign bit
        x_mem[0] = 32'h7FFF_FFFF; w_mem[0] = 32'd2;
        run_case("wrap", 1, 32'd0, -1);

        // randomized runs, back to back
        n_rand = 12;
        for (int r = 0; r < n_rand; r++) begin
            int nr;
            for (int i = 0; i < 16; i++) begin
                x_mem[i] = (r % 2 == 0) ? $urandom : 32'($urandom_range(0, 255)) - 32'd100;
                w_mem[i] = (r % 2 == 0) ? $urandom : 32'($urandom_range(0, 255)) - 32'd100;
            end
            nr = $urandom_range(0, 20);
            run_case("rand", nr, $urandom, $urandom_range(1, 2 * ((nr > 16) ? 16 : nr) + 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/neuron_op_sequencer.md
# neuron_op_sequencer

Control-side counterpart to the team's combinational execution-unit ALU. It evaluates one neuron, y = act(bias + Σ x[i]·w[i]), by issuing a timed sequence of ALU operations: multiply, add, then set-if-non-negative. It drives the ALU's `ALU1Control`, `SrcA` and `SrcB` inputs and captures `ALUResult` on each step. It sits between the input/weight register files and the ALU inside the CPU_NN datapath.

## Interface
Parameters:
- `nBits`, 32, datapath width; must match the ALU.
- `MAX_N`, 16, maximum number of inputs per neuron.
- `IDX_W`, 4, read-address width; equals clog2(`MAX_N`).

Ports:
- `clk`, in, 1, single clock, rising edge.
- `reset_n`, in, 1, asynchronous active-low reset.
- `start`, in, 1, request a neuron evaluation; sampled only in IDLE.
- `num_inputs`, in, `IDX_W`+1, N; values above `MAX_N` are clamped to `MAX_N`.
- `bias`, in, `nBits`, signed initial accumulator value.
- `rd_addr`, out, `IDX_W`, input/weight index; the register files return data combinationally.
- `rd_x`, in, `nBits`, input operand at `rd_addr`.
- `rd_w`, in, `nBits`, weight operand at `rd_addr`.
- `ALU1Control`, out, 3, ALU opcode.
- `SrcA`, out, `nBits`, ALU operand A.
- `SrcB`, out, `nBits`, ALU operand B.
- `ALUResult`, in, `nBits`, combinational ALU result.
- `busy`, out, 1, high in every state except IDLE.
- `done`, out, 1, one-cycle pulse when `y` and `acc` are valid.
- `acc`, out, `nBits`, pre-activation sum.
- `y`, out, `nBits`, activation result.

## Operation
- IDLE: drive PASS (3'b111) with `SrcA`=`acc` and `SrcB`=0.
  - On `start` with N>0: load `acc` from `bias`, set idx to 0, go to MUL.
  - On `start` with N=0: load `acc` from `bias`, go to ACT.
- MUL: drive MUL (3'b001) with `rd_addr`=idx, `SrcA`=`rd_x`, `SrcB`=`rd_w`. Register `prod` from `ALUResult`. Go to ADD.
- ADD: drive ADD (3'b000) with `SrcA`=`acc`, `SrcB`=`prod`. Update `acc` from `ALUResult`.
  - If idx==N-1, go to ACT.
  - Otherwise increment idx and go to MUL.
- ACT: drive SNN (3'b010) with `SrcA`=`acc`, `SrcB`=0. Register `y` from `ALUResult`, which is 1 if the MSB of `acc` is 0 and 0 otherwise. Go to DONE.
- DONE: assert `done` for one cycle, then go to IDLE. `acc` and `y` hold until the next `start`.
- Arithmetic wraps modulo 2^`nBits`. The block adds no saturation beyond the ALU's own truncation.
- `start` while `busy` is ignored and is not queued.
- `rd_addr` is 0 outside MUL.

## Timing
- Reset values: `busy`, `done`, `acc`, `y`, `rd_addr` and `SrcA` are 0. `SrcB` is 0. `ALU1Control` is 3'b111. State is IDLE.
- `start` is sampled at edge 0. The sequence occupies cycles 1..2N as alternating MUL/ADD, ACT at cycle 2N+1, and `done` high during cycle 2N+2.
  - N=0 gives `done` in cycle 2.
  - The next `start` is accepted one cycle after `done` at the earliest.
- Reset asserted mid-operation aborts immediately to IDLE with all outputs at their reset values. No partial `done` is produced.
- `num_inputs` and `bias` are sampled only at the `start` edge. Later changes to them have no effect on the running evaluation.

## Configuration
- `NEURON_SEQ_RELU_EN` defined: in ACT, `y` = `ALUResult[0]` ? `acc` : 0, i.e. ReLU. Latency is unchanged.
- `NEURON_SEQ_RELU_EN` undefined: `y` = `ALUResult`, i.e. a 0/1 step.

## Structure
- Shared package `nn_pkg` holds:
  - ALU opcode constants: `ALU_ADD`=3'b000, `ALU_MUL`=3'b001, `ALU_SNN`=3'b010, `ALU_PASS`=3'b111.
  - The sequencer state enum.
  - `MAX_N`.
- No sub-module is needed; the FSM, index counter and registers fit in one module. The ALU is instantiated beside this block by the parent datapath and the bench, never inside it.

## Test plan
- N=3, x={1,2,3}, w={4,5,6}, `bias`=0 → `done` in cycle 8, `acc`=32, `y`=1.
- Same vectors with `bias`=-40 → `acc`=0xFFFFFFF8, `y`=0 in both configurations.
- N=0, `bias`=5 → `done` in cycle 2, `acc`=5, `y`=1 (step) or `y`=5 (RELU).
- `num_inputs`=20 with all x=w=1 and `bias`=0 → clamped to 16; `done` in cycle 34, `acc`=16. A second `start` pulsed at cycle 10 is ignored.
- `reset_n` low during an ADD cycle → all outputs at reset values and state IDLE. A following N=2 run with x={2,3}, w={2,3} gives `acc`=13.
- x=0x7FFFFFFF, w=2, `bias`=0, N=1 → `acc`=0xFFFFFFFE from the wrap, `y`=0. The opcode trace per cycle is 111, 001, 000, 010, 111.
